// File: rtl/pc_pkg.sv
// Shared definitions for the pc_seq fetch-stage program counter:
// PC-select encodings and the matching enum.
package pc_pkg;

  localparam logic [2:0] PS_HOLD   = 3'b000;
  localparam logic [2:0] PS_INC    = 3'b001;
  localparam logic [2:0] PS_BRANCH = 3'b010;
  localparam logic [2:0] PS_JUMP   = 3'b011;
  localparam logic [2:0] PS_CALL   = 3'b100;
  localparam logic [2:0] PS_RET    = 3'b101;

  // Every 3-bit code has a member, so a cast from the raw select is always legal.
  typedef enum logic [2:0] {
    SEL_HOLD   = PS_HOLD,
    SEL_INC    = PS_INC,
    SEL_BRANCH = PS_BRANCH,
    SEL_JUMP   = PS_JUMP,
    SEL_CALL   = PS_CALL,
    SEL_RET    = PS_RET,
    SEL_RSV6   = 3'b110,
    SEL_RSV7   = 3'b111
  } pc_ps_t;

endpackage

// File: rtl/pc_seq_if.sv
// Control/status bundle between the fetch controller (master) and pc_seq (slave).
interface pc_seq_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
);
  localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

  logic [2:0]      ps;
  logic [XLEN-3:0] in;
  logic            stall;
  logic            trap;
  logic            err_clr;
  logic [XLEN-1:0] q;
  logic [XLEN-1:0] epc;
  logic [CW-1:0]   ras_count;
  logic            ras_empty;
  logic            ras_full;
  logic            ras_err;

  modport master (
    output ps, in, stall, trap, err_clr,
    input  q, epc, ras_count, ras_empty, ras_full, ras_err
  );

  modport slave (
    input  ps, in, stall, trap, err_clr,
    output q, epc, ras_count, ras_empty, ras_full, ras_err
  );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: a full push overwrites the oldest entry,
// a pop on empty leaves state unchanged; both raise a one-cycle error pulse.
module pc_ras #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           push,
  input  logic                           pop,
  input  logic [XLEN-1:0]                push_data,
  output logic [XLEN-1:0]                top_data,
  output logic [$clog2(RAS_DEPTH):0]     count,
  output logic                           overflow,
  output logic                           underflow
);
  localparam int unsigned AW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]   ptr_q, ptr_d, top_idx;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic            full, empty;

  // ptr_q addresses the next free slot; the top of stack sits just below it.
  assign top_idx   = ptr_q - AW'(1);
  assign top_data  = mem_q[top_idx];
  assign full      = (cnt_q == CW'(RAS_DEPTH));
  assign empty     = (cnt_q == '0);
  assign count     = cnt_q;
  assign overflow  = push & full;
  assign underflow = pop & empty;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      ptr_d = ptr_q + AW'(1);
      if (!full) cnt_d = cnt_q + CW'(1);
    end else if (pop && !empty) begin
      ptr_d = ptr_q - AW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[ptr_q] <= push_data;
  end
endmodule

// File: rtl/pc_seq.sv
// Fetch-stage program counter: hold/inc/branch/jump/call/ret with trap
// redirect, stall, return-address stack and a sticky RAS error flag.
module pc_seq
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h8000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h8000_0100),
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input logic      clock,
  input logic      reset_n,
  pc_seq_if.slave  bus
);
  localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

  if (RESET_VECTOR[1:0] != 2'b00) begin : g_bad_reset_vector
    $error("pc_seq: RESET_VECTOR must be word aligned");
  end
  if (TRAP_VECTOR[1:0] != 2'b00) begin : g_bad_trap_vector
    $error("pc_seq: TRAP_VECTOR must be word aligned");
  end
  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras_depth
    $error("pc_seq: RAS_DEPTH must be a power of two >= 2");
  end

  logic [XLEN-1:0] q_q, q_d, epc_q, epc_d, pc_inc, ras_top;
  logic            err_q, err_d;
  logic            push, pop, ovf, udf;
  logic [CW-1:0]   count;
  pc_ps_t          sel;

  assign sel    = pc_ps_t'(bus.ps);
  assign pc_inc = q_q + XLEN'(4);

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top_data  (ras_top),
    .count     (count),
    .overflow  (ovf),
    .underflow (udf)
  );

  always_comb begin
    q_d   = q_q;
    epc_d = epc_q;
    push  = 1'b0;
    pop   = 1'b0;
    if (bus.trap) begin
      epc_d = q_q;
      q_d   = TRAP_VECTOR;
    end else if (!bus.stall) begin
      case (sel)
        SEL_INC:    q_d = pc_inc;
        // {in,2'b00} already equals sign_extend(in)<<2 modulo 2^XLEN.
        SEL_BRANCH: q_d = pc_inc + {bus.in, 2'b00};
        SEL_JUMP:   q_d = {bus.in, 2'b00};
        SEL_CALL: begin
          push = 1'b1;
          q_d  = {bus.in, 2'b00};
        end
        SEL_RET: begin
          pop = 1'b1;
          q_d = (count == '0) ? pc_inc : ras_top;
        end
        default: q_d = q_q;
      endcase
    end
    err_d = (ovf | udf) ? 1'b1 : (bus.err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_q   <= RESET_VECTOR;
      epc_q <= '0;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      epc_q <= epc_d;
      err_q <= err_d;
    end
  end

  assign bus.q         = q_q;
  assign bus.epc       = epc_q;
  assign bus.ras_count = count;
  assign bus.ras_empty = (count == '0);
  assign bus.ras_full  = (count == CW'(RAS_DEPTH));
  assign bus.ras_err   = err_q;
endmodule

// File: tb/tb_pc_seq.sv
// Directed, table-driven bench for pc_seq with hand-computed expectations.
module tb_pc_seq;
  import pc_pkg::*;

  logic clock;
  logic reset_n;
  int   n_chk;
  int   n_fail;

  pc_seq_if #(.XLEN(32), .RAS_DEPTH(4)) bus ();

  pc_seq #(
    .XLEN         (32),
    .RESET_VECTOR (32'h8000_0000),
    .TRAP_VECTOR  (32'h8000_0100),
    .RAS_DEPTH    (4)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  ps;
    logic [29:0] opnd;
    logic        stall;
    logic        trap;
    logic        clr;
    logic [31:0] exp_q;
    logic [31:0] exp_epc;
    logic [2:0]  exp_cnt;
    logic        exp_err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [2:0] ps, input logic [29:0] opnd, input logic st,
                     input logic tr, input logic cl, input logic [31:0] q,
                     input logic [31:0] epc, input logic [2:0] cnt, input logic err);
    vec_t v;
    v.ps = ps; v.opnd = opnd; v.stall = st; v.trap = tr; v.clr = cl;
    v.exp_q = q; v.exp_epc = epc; v.exp_cnt = cnt; v.exp_err = err;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] q, input logic [31:0] epc,
                         input logic [2:0] cnt, input logic err);
    chk({tag, " q"},     bus.q, q);
    chk({tag, " epc"},   bus.epc, epc);
    chk({tag, " count"}, 32'(bus.ras_count), 32'(cnt));
    chk({tag, " empty"}, 32'(bus.ras_empty), 32'(cnt == 3'd0));
    chk({tag, " full"},  32'(bus.ras_full), 32'(cnt == 3'd4));
    chk({tag, " err"},   32'(bus.ras_err), 32'(err));
  endtask

  task automatic drive(input logic [2:0] ps, input logic [29:0] opnd, input logic st,
                       input logic tr, input logic cl);
    bus.ps = ps; bus.in = opnd; bus.stall = st; bus.trap = tr; bus.err_clr = cl;
  endtask

  localparam logic [29:0] M1 = 30'h3FFF_FFFF;
  localparam logic [29:0] M2 = 30'h3FFF_FFFE;
  localparam logic [31:0] TV = 32'h8000_0100;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset_n = 1'b0;
    drive(PS_HOLD, '0, 1'b0, 1'b0, 1'b0);

    //  ps         in            st    tr    clr   q             epc           cnt   err
    add(PS_INC,    30'h0,        1'b0, 1'b0, 1'b0, 32'h8000_0004, 32'h0,        3'd0, 1'b0);
    add(PS_INC,    30'h0,        1'b0, 1'b0, 1'b0, 32'h8000_0008, 32'h0,        3'd0, 1'b0);
    add(PS_INC,    30'h0,        1'b0, 1'b0, 1'b0, 32'h8000_000C, 32'h0,        3'd0, 1'b0);
    add(PS_INC,    30'h0,        1'b0, 1'b0, 1'b0, 32'h8000_0010, 32'h0,        3'd0, 1'b0);
    add(PS_BRANCH, M1,           1'b0, 1'b0, 1'b0, 32'h8000_0010, 32'h0,        3'd0, 1'b0);
    add(PS_BRANCH, 30'h3,        1'b0, 1'b0, 1'b0, 32'h8000_0020, 32'h0,        3'd0, 1'b0);
    add(PS_BRANCH, M2,           1'b0, 1'b0, 1'b0, 32'h8000_001C, 32'h0,        3'd0, 1'b0);
    add(PS_JUMP,   M1,           1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,        3'd0, 1'b0);
    add(PS_INC,    30'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0,        3'd0, 1'b0);
    add(PS_HOLD,   30'h5,        1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0,        3'd0, 1'b0);
    add(3'b110,    30'h5,        1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0,        3'd0, 1'b0);
    add(3'b111,    30'h5,        1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0,        3'd0, 1'b0);
    add(PS_JUMP,   30'h2000_0000,1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0,        3'd0, 1'b0);
    add(PS_CALL,   30'h100,      1'b0, 1'b0, 1'b0, 32'h0000_0400, 32'h0,        3'd1, 1'b0);
    add(PS_RET,    30'h0,        1'b0, 1'b0, 1'b0, 32'h8000_0004, 32'h0,        3'd0, 1'b0);
    add(PS_RET,    30'h0,        1'b0, 1'b0, 1'b0, 32'h8000_0008, 32'h0,        3'd0, 1'b1);
    add(PS_HOLD,   30'h0,        1'b0, 1'b0, 1'b0, 32'h8000_0008, 32'h0,        3'd0, 1'b1);
    add(PS_HOLD,   30'h0,        1'b0, 1'b0, 1'b1, 32'h8000_0008, 32'h0,        3'd0, 1'b0);
    add(PS_JUMP,   30'h2000_0008,1'b0, 1'b0, 1'b0, 32'h8000_0020, 32'h0,        3'd0, 1'b0);
    add(PS_INC,    30'h0,        1'b1, 1'b1, 1'b0, TV,            32'h8000_0020, 3'd0, 1'b0);
    add(PS_INC,    30'h0,        1'b1, 1'b0, 1'b0, TV,            32'h8000_0020, 3'd0, 1'b0);
    add(PS_RET,    30'h0,        1'b1, 1'b0, 1'b0, TV,            32'h8000_0020, 3'd0, 1'b0);
    add(PS_CALL,   30'h10,       1'b0, 1'b1, 1'b0, TV,            TV,            3'd0, 1'b0);
    add(PS_CALL,   30'h40,       1'b0, 1'b0, 1'b0, 32'h0000_0100, TV,            3'd1, 1'b0);
    add(PS_CALL,   30'h80,       1'b0, 1'b0, 1'b0, 32'h0000_0200, TV,            3'd2, 1'b0);
    add(PS_CALL,   30'hC0,       1'b0, 1'b0, 1'b0, 32'h0000_0300, TV,            3'd3, 1'b0);
    add(PS_CALL,   30'h100,      1'b0, 1'b0, 1'b0, 32'h0000_0400, TV,            3'd4, 1'b0);
    add(PS_CALL,   30'h140,      1'b0, 1'b0, 1'b1, 32'h0000_0500, TV,            3'd4, 1'b1);
    add(PS_RET,    30'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0404, TV,            3'd3, 1'b0);
    add(PS_RET,    30'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0304, TV,            3'd2, 1'b0);
    add(PS_RET,    30'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0204, TV,            3'd1, 1'b0);
    add(PS_RET,    30'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0104, TV,            3'd0, 1'b0);
    add(PS_RET,    30'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0108, TV,            3'd0, 1'b1);

    #12;
    chk_all("reset", 32'h8000_0000, 32'h0, 3'd0, 1'b0);
    reset_n = 1'b1;

    for (int unsigned i = 0; i < vq.size(); i++) begin
      drive(vq[i].ps, vq[i].opnd, vq[i].stall, vq[i].trap, vq[i].clr);
      @(posedge clock);
      #1;
      chk_all($sformatf("vec%0d", i), vq[i].exp_q, vq[i].exp_epc, vq[i].exp_cnt, vq[i].exp_err);
    end

    // Asynchronous reset in the middle of a call sequence.
    drive(PS_CALL, 30'h40, 1'b0, 1'b0, 1'b0);
    @(posedge clock); #1;
    chk_all("mid_call1", 32'h0000_0100, TV, 3'd1, 1'b1);
    drive(PS_CALL, 30'h80, 1'b0, 1'b0, 1'b0);
    @(posedge clock); #1;
    chk_all("mid_call2", 32'h0000_0200, TV, 3'd2, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk_all("async_rst", 32'h8000_0000, 32'h0, 3'd0, 1'b0);
    @(posedge clock); #1;
    chk_all("rst_held", 32'h8000_0000, 32'h0, 3'd0, 1'b0);
    reset_n = 1'b1;
    drive(PS_RET, 30'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clock); #1;
    chk_all("ret_after_rst", 32'h8000_0004, 32'h0, 3'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
